// File: rtl/fft8_sequencer.sv
// rtl/fft8_sequencer.sv - load/compute/unload sequencer for an 8-point radix-2 DIT FFT datapath
// FFT8_IFFT_EN adds the inverse input and the bf_conj output.
module fft8_sequencer #(
  parameter int BF_LAT = 2,
  parameter int N_PTS  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ld_wr_en,
  output logic [2:0] ld_wr_addr,
  output logic       bf_issue,
  output logic [2:0] bf_addr_a,
  output logic [2:0] bf_addr_b,
  output logic [1:0] bf_tw_idx,
  output logic       bf_wr_en,
  output logic [2:0] bf_wr_addr_a,
  output logic [2:0] bf_wr_addr_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_rd_addr,
  output logic       busy,
`ifdef FFT8_IFFT_EN
  input  logic       inverse,
  output logic       bf_conj,
`endif
  output logic       done
);

  if (N_PTS != 8) begin : g_bad_npts
    $error("fft8_sequencer: N_PTS must be 8");
  end
  if (BF_LAT < 1 || BF_LAT > 8) begin : g_bad_lat
    $error("fft8_sequencer: BF_LAT must be in 1..8");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

  // A stage issues for 4 cycles, then waits for its last result to land.
  localparam logic [3:0] STAGE_LAST = 4'(BF_LAT + 3);

  state_t     state_q;
  logic [2:0] load_cnt_q;
  logic [2:0] out_cnt_q;
  logic [1:0] stage_q;
  logic [3:0] cyc_q;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       done_q;
  logic [6:0] wb_q [BF_LAT];

  logic       ld_hs;
  logic       out_hs;
  logic       issue_d;
  logic [1:0] k;
  logic [2:0] addr_a_d;
  logic [2:0] addr_b_d;
  logic [1:0] tw_d;

  assign ld_hs   = in_valid & in_ready_q;
  assign out_hs  = out_valid_q & out_ready;
  assign k       = cyc_q[1:0];
  assign issue_d = (state_q == S_COMPUTE) && (cyc_q < 4'd4);

  // Addresses are forced to zero off-issue so idle and reset values stay clean.
  always_comb begin
    addr_a_d = 3'd0;
    addr_b_d = 3'd0;
    tw_d     = 2'd0;
    if (issue_d) begin
      case (stage_q)
        2'd0: begin
          addr_a_d = {k, 1'b0};
          addr_b_d = {k, 1'b1};
          tw_d     = 2'd0;
        end
        2'd1: begin
          addr_a_d = {k[1], 1'b0, k[0]};
          addr_b_d = {k[1], 1'b1, k[0]};
          tw_d     = {k[0], 1'b0};
        end
        default: begin
          addr_a_d = {1'b0, k};
          addr_b_d = {1'b1, k};
          tw_d     = k;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      load_cnt_q  <= 3'd0;
      out_cnt_q   <= 3'd0;
      stage_q     <= 2'd0;
      cyc_q       <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_LOAD: begin
          if (ld_hs) begin
            load_cnt_q <= load_cnt_q + 3'd1;
            state_q    <= S_LOAD;
            if (load_cnt_q == 3'd7) begin
              state_q    <= S_COMPUTE;
              in_ready_q <= 1'b0;
            end
          end
        end
        S_COMPUTE: begin
          if (cyc_q == STAGE_LAST) begin
            cyc_q <= 4'd0;
            if (stage_q == 2'd2) begin
              stage_q     <= 2'd0;
              state_q     <= S_UNLOAD;
              out_valid_q <= 1'b1;
            end else begin
              stage_q <= stage_q + 2'd1;
            end
          end else begin
            cyc_q <= cyc_q + 4'd1;
          end
        end
        S_UNLOAD: begin
          if (out_hs) begin
            out_cnt_q <= out_cnt_q + 3'd1;
            if (out_cnt_q == 3'd7) begin
              state_q     <= S_IDLE;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              in_ready_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Writeback delay line: {valid, addr_a, addr_b}, flushed by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BF_LAT; i++) wb_q[i] <= 7'd0;
    end else begin
      wb_q[0] <= {issue_d, addr_a_d, addr_b_d};
      for (int i = 1; i < BF_LAT; i++) wb_q[i] <= wb_q[i-1];
    end
  end

`ifdef FFT8_IFFT_EN
  logic inv_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inv_q <= 1'b0;
    end else if (ld_hs && state_q == S_IDLE) begin
      inv_q <= inverse;
    end
  end

  assign bf_conj = issue_d & inv_q;
`endif

  assign in_ready     = in_ready_q;
  assign ld_wr_en     = ld_hs;
  assign ld_wr_addr   = {load_cnt_q[0], load_cnt_q[1], load_cnt_q[2]};
  assign bf_issue     = issue_d;
  assign bf_addr_a    = addr_a_d;
  assign bf_addr_b    = addr_b_d;
  assign bf_tw_idx    = tw_d;
  assign bf_wr_en     = wb_q[BF_LAT-1][6];
  assign bf_wr_addr_a = wb_q[BF_LAT-1][5:3];
  assign bf_wr_addr_b = wb_q[BF_LAT-1][2:0];
  assign out_valid    = out_valid_q;
  assign out_rd_addr  = out_cnt_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;

endmodule

// File: doc/fft8_sequencer.md
Name: fft8_sequencer

Overview:
- Control FSM for the 8-point radix-2 DIT FFT datapath with Q8.8 samples.
- Schedules one shared, pipelined butterfly unit across 3 stages × 4 butterflies.
- Generates addresses for a shared 8-entry complex sample RAM: bit-reversed load, in-place compute, natural-order unload.
- Carries no sample data. It only drives addresses, enables and handshakes.

Parameters:
- BF_LAT, 2, butterfly pipeline latency in cycles from bf_issue to result writeback. Legal range 1–8.
- N_PTS, 8, transform size. Fixed at 8; any other value is an elaboration error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  input sample present.
- in_ready  out  1  sequencer accepts sample this cycle.
- ld_wr_en  out  1  RAM write strobe for the accepted input sample.
- ld_wr_addr  out  3  bit-reversed load address.
- bf_issue  out  1  butterfly operands valid this cycle.
- bf_addr_a  out  3  RAM read address, upper leg.
- bf_addr_b  out  3  RAM read address, lower leg.
- bf_tw_idx  out  2  twiddle index k selecting W8^k.
- bf_wr_en  out  1  butterfly result writeback strobe.
- bf_wr_addr_a  out  3  writeback address, upper leg.
- bf_wr_addr_b  out  3  writeback address, lower leg.
- out_valid  out  1  output sample at out_rd_addr is valid.
- out_ready  in  1  consumer accepts output.
- out_rd_addr  out  3  natural-order unload address.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the final output handshake.

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE; all counters clear.
  - All outputs reset to 0 except in_ready, which resets to 1.
  - Reset aborts any frame in progress. The butterfly pipeline shift register is flushed, so no bf_wr_en fires after reset.
- States: IDLE → LOAD → COMPUTE → UNLOAD → IDLE.
- IDLE:
  - in_ready = 1.
  - An in_valid handshake writes sample 0 and moves to LOAD with load count = 1.
- LOAD:
  - Each handshake asserts ld_wr_en in the same cycle, with ld_wr_addr = bitrev3(load count).
  - Gaps on in_valid stall the FSM; no timeout.
  - After the 8th handshake, in_ready drops on the next cycle and the FSM enters COMPUTE.
- COMPUTE, for stage s = 0..2 and butterfly k = 0..3:
  - span = 2^s
  - bf_addr_a = (k>>s)*2*span + (k & (span−1))
  - bf_addr_b = bf_addr_a + span
  - bf_tw_idx = (k & (span−1)) << (2−s)
  - Resulting address pairs:
    - s0: (0,1)(2,3)(4,5)(6,7), tw 0.
    - s1: (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2.
    - s2: (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3.
- Issue and writeback timing:
  - bf_issue is high on 4 consecutive cycles per stage.
  - The writeback addresses follow issue through a BF_LAT-deep shift register. bf_wr_en and bf_wr_addr_a/b appear exactly BF_LAT cycles after the matching bf_issue.
  - Read-after-write hazard: the first issue of stage s+1 occurs the cycle after the last bf_wr_en of stage s.
  - Each stage takes 4 + BF_LAT cycles; all of COMPUTE takes 3·(4+BF_LAT) cycles.
  - bf_issue and bf_wr_en are never high in the same cycle for the same address.
- UNLOAD:
  - out_valid = 1 with out_rd_addr = 0..7 in natural order.
  - The address advances only on an out_valid && out_ready handshake.
  - While out_ready is low, out_valid and out_rd_addr hold.
  - After the handshake at address 7: done pulses on the next cycle, the FSM enters IDLE, and in_ready = 1 on that same cycle.
- in_valid outside IDLE/LOAD is ignored; nothing is written.
- Counters are 3-bit and wrap only at frame boundaries.

Optional Feature:
- Macro: FFT8_IFFT_EN.
- Defined:
  - Adds input port inverse (1 bit) and output port bf_conj (1 bit).
  - inverse is sampled on the first load handshake and held for the whole frame.
  - bf_conj = latched inverse on every bf_issue cycle, 0 otherwise; it resets to 0.
  - Addressing and timing are unchanged.
- Undefined: the ports are absent and behaviour is as specified above.

Test Plan:
- Reset and streaming:
  - Stimulus: reset, then 8 back-to-back in_valid with out_ready = 1 and BF_LAT = 2.
  - Required: ld_wr_addr sequence 0,4,2,6,1,5,3,7; COMPUTE lasts 18 cycles; done pulses exactly one cycle after the 8th output handshake.
- Issue sequence:
  - Stimulus: check bf_issue addresses and twiddles across all 12 butterflies.
  - Required: pairs and tw indices match the s0/s1/s2 lists above.
  - Required: first s1 issue occurs one cycle after the 4th s0 bf_wr_en.
- Latency sweep:
  - Stimulus: BF_LAT = 1, then BF_LAT = 5.
  - Required: every bf_wr_en is exactly BF_LAT cycles after its issue with matching addresses; total COMPUTE is 15 and 27 cycles respectively.
- Backpressure and input gaps:
  - Stimulus: gaps on in_valid during LOAD; out_ready low for 3 cycles at out_rd_addr = 3.
  - Required: FSM stalls; out_rd_addr holds at 3 with out_valid held high; no extra writes occur.
- Reset mid-COMPUTE:
  - Stimulus: assert rst_n low during stage 1, 1 cycle after a bf_issue.
  - Required: no bf_wr_en after reset; outputs return to reset values; in_ready = 1 on the next cycle.
- FFT8_IFFT_EN:
  - Stimulus: inverse = 1 on the first sample, then 0 for the rest of the frame.
  - Required: bf_conj = 1 on all 12 issues; the next frame started with inverse = 0 gives bf_conj = 0.
